// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, instruction field layout and fetch-state encoding
package cpu_pkg;

    localparam int INSTR_W_DEFAULT = 16;
    localparam int OPCODE_W        = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_MUL   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, single-outstanding instruction fetch and decode handshake
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int INSTR_W  = INSTR_W_DEFAULT,
    parameter int PC_W     = 8,
    parameter int PC_RESET = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         accept;
    logic         load_instr;

    // halt arrives combinationally from the control unit, so it only counts
    // together with a real accept
    assign accept     = dec_valid && dec_ready;
    assign load_instr = (state == ST_FETCH) && imem_valid;

    assign imem_addr = pc;
    assign opcode    = instr[INSTR_W-1 -: OPCODE_W];

    // next-state decode of the fetch sequence
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dec_ready) begin
                    state_next = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // state register plus handshake outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            imem_req  <= 1'b0;
            dec_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            imem_req  <= (state_next == ST_FETCH);
            dec_valid <= (state_next == ST_HOLD);
            halted    <= (state_next == ST_HALTED);
        end
    end

    // instruction capture, PC advance and saturating retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            instr   <= '0;
            pc      <= PC_W'(PC_RESET);
            retired <= '0;
        end else begin
            if (load_instr) begin
                instr <= imem_rdata;
            end
            if (accept && !halt) begin
                pc <= pc + PC_W'(1);
                if (retired != {CNT_W{1'b1}}) begin
                    retired <= retired + CNT_W'(1);
                end
            end
        end
    end

endmodule
